keypad_scan_zyq: RTL and testbench
==================================

Name: keypad_scan_zyq

Overview:
4x4 matrix keypad scanner and digit-entry register. It is the input-side counterpart of the 8-digit multiplexed display driver: it drives keypad columns one at a time, samples the rows, debounces, and decodes a single keypress to a hex code. Accepted digits shift into a 32-bit register that feeds the display's 32-bit data input directly.

Parameters:
SCAN_DIV, 50000, clock cycles each column is driven; must be >= 2
DEBOUNCE, 4, consecutive identical full-scan frames needed to accept a press or a release; 1..15

Ports:
CLK  input  1  system clock
RST  input  1  synchronous reset, active-high
clr  input  1  synchronous clear of dataout and digit_cnt; does not affect the scan or debounce logic
row_n  input  4  keypad rows, active-low (external pull-ups), asynchronous to CLK
col_n  output  4  keypad column drive, active-low, exactly one bit low at all times
key_valid  output  1  one-cycle pulse on each accepted press
key_code  output  4  hex code of the last accepted key, held between presses
dataout  output  32  entered digits; newest digit in [3:0]
digit_cnt  output  4  digits entered since reset/clr, saturates at 8

Behaviour:
- Clock: single clock CLK. Reset: RST, synchronous, active-high.
- Reset values: col_n=4'b1110, key_valid=0, key_code=0, dataout=0, digit_cnt=0; divider, column index, frame snapshot, and debounce counter all 0; FSM in IDLE.
- row_n passes through a 2-flop synchronizer before any use.
- Divider counts 0..SCAN_DIV-1. The column index (0..3) advances on the wrap; col_n = ~(1<<col). Column 3 wraps to column 0.
- Rows are sampled into the snapshot only on the last divider cycle of each column (divider==SCAN_DIV-1). This gives settling time.
- Frame end is the last divider cycle of column 3. One frame lasts 4*SCAN_DIV cycles.
- Frame classification:
  - NONE: no bits low.
  - ONE: exactly one bit low; candidate code = row*4 + col (row0/col0 -> 0x0, row3/col3 -> 0xF).
  - MULTI: two or more bits low.
- FSM, evaluated only at frame end, with debounce counter dbc:
  - IDLE: ONE -> PRESS_DB, latch candidate, dbc=1. NONE/MULTI -> stay.
  - PRESS_DB:
    - ONE with same candidate: dbc++. When dbc reaches DEBOUNCE -> HELD and accept.
    - ONE with a different candidate: relatch candidate, dbc=1.
    - NONE or MULTI -> IDLE, dbc=0.
  - HELD:
    - NONE -> RELEASE_DB, dbc=1.
    - ONE or MULTI -> stay. A second key added while held is ignored; no repeat.
  - RELEASE_DB:
    - NONE: dbc++. When dbc reaches DEBOUNCE -> IDLE.
    - ONE or MULTI -> HELD, dbc=0.
  - With DEBOUNCE=1, accept from IDLE and release from HELD each occur on the first qualifying frame.
- Accept happens on the CLK edge after the frame-end cycle:
  - key_valid=1 for exactly one cycle.
  - key_code <= candidate.
  - dataout <= {dataout[27:0], candidate}.
  - digit_cnt <= min(digit_cnt+1, 8).
- The oldest digit is shifted out of dataout[31:28]; there is no overflow flag.
- clr and accept in the same cycle: clr wins. dataout=0 and digit_cnt=0, but key_valid still pulses and key_code still updates.
- Reset mid-scan or mid-debounce returns everything to reset values on the next edge. A key held through reset must pass full press debounce again from IDLE.

Test Plan:
- SCAN_DIV=4, DEBOUNCE=2; hold row1 low only while col2 is driven -> one key_valid pulse after 2 frames, key_code=0x6, dataout=0x00000006, digit_cnt=1. No further pulse while held.
- Press/release sequence 1,2,3,...,9,A with full release between presses -> dataout=0x3456789A, digit_cnt=8 (saturated), exactly 10 pulses.
- Bounce: key 0x5 present 1 frame, absent 1 frame, repeated ×3 -> no key_valid. Then held 2 frames -> single pulse, key_code=0x5.
- Two keys (0x0 and 0x3) pressed together from IDLE -> no pulse. Release 0x3 while holding 0x0 -> pulse with key_code=0x0 after 2 frames.
- Assert clr in the same cycle as an accept of 0xB with dataout=0x12 -> dataout=0, digit_cnt=0, key_valid=1, key_code=0xB.
- RST asserted mid-PRESS_DB with the key still held -> col_n=4'b1110 and all outputs 0 next cycle. After release of RST, the pulse arrives only after 2 full new frames.

Source files
------------

// File: rtl/keypad_scan_zyq.sv
// keypad_scan_zyq: 4x4 matrix keypad scanner with debounce and a 32-bit digit-entry shift register
module keypad_scan_zyq #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] dataout,
  output logic [3:0]  digit_cnt
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [3:0] DB = 4'(DEBOUNCE);
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;
  state_t      state_q;
  logic [DW-1:0] div_q;
  logic [1:0]  col_q;
  logic [3:0]  sync1_q, sync2_q;
  logic [15:0] snap_q, snap_d;
  logic [4:0]  nlow;
  logic [3:0]  cand, cand_q, dbc_q, key_code_q, cnt_q;
  logic        last, frame_end, one, none, accept_d, key_valid_q;
  logic [31:0] dataout_q;
  assign last      = div_q == DW'(SCAN_DIV - 1);
  assign frame_end = last && col_q == 2'd3;
  assign one       = nlow == 5'd1;
  assign none      = nlow == 5'd0;
  assign col_n     = ~(4'b0001 << col_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign dataout   = dataout_q;
  assign digit_cnt = cnt_q;
  // Merge the current column's rows into the frame on its last cycle, so frame end sees all four columns
  always_comb begin
    snap_d = snap_q;
    for (int r = 0; r < 4; r++)
      if (last) snap_d[{2'(r), col_q}] = ~sync2_q[r];
  end
  // Count pressed positions in the frame and keep the code of one of them as candidate
  always_comb begin
    nlow = '0;
    cand = '0;
    for (int i = 0; i < 16; i++)
      if (snap_d[i]) begin
        nlow = nlow + 5'd1;
        cand = 4'(i);
      end
  end
  // A key is accepted on the frame where its stable-press count reaches DEBOUNCE
  always_comb
    accept_d = frame_end && one &&
               ((state_q == IDLE && DB == 4'd1) ||
                (state_q == PRESS_DB && cand == cand_q && dbc_q + 4'd1 == DB));
  // Column divider and scan position
  always_ff @(posedge CLK)
    if (RST) begin
      div_q <= '0;
      col_q <= '0;
    end else begin
      div_q <= last ? '0 : div_q + DW'(1);
      col_q <= last ? col_q + 2'd1 : col_q;
    end
  // Row synchronizer and frame snapshot
  always_ff @(posedge CLK)
    if (RST) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      snap_q  <= '0;
    end else begin
      sync1_q <= row_n;
      sync2_q <= sync1_q;
      snap_q  <= snap_d;
    end
  // Press/release debounce FSM, stepped once per frame, with registered key outputs
  always_ff @(posedge CLK)
    if (RST) begin
      state_q     <= IDLE;
      dbc_q       <= '0;
      cand_q      <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      key_valid_q <= accept_d;
      if (accept_d) key_code_q <= cand;
      if (frame_end)
        case (state_q)
          IDLE:
            if (one) begin
              cand_q  <= cand;
              dbc_q   <= accept_d ? 4'd0 : 4'd1;
              state_q <= accept_d ? HELD : PRESS_DB;
            end
          PRESS_DB:
            if (!one) begin
              state_q <= IDLE;
              dbc_q   <= '0;
            end else if (cand != cand_q) begin
              cand_q <= cand;
              dbc_q  <= 4'd1;
            end else if (accept_d) begin
              state_q <= HELD;
              dbc_q   <= '0;
            end else dbc_q <= dbc_q + 4'd1;
          HELD:
            if (none) begin
              state_q <= DB == 4'd1 ? IDLE : RELEASE_DB;
              dbc_q   <= DB == 4'd1 ? 4'd0 : 4'd1;
            end
          RELEASE_DB:
            if (!none) begin
              state_q <= HELD;
              dbc_q   <= '0;
            end else if (dbc_q + 4'd1 == DB) begin
              state_q <= IDLE;
              dbc_q   <= '0;
            end else dbc_q <= dbc_q + 4'd1;
        endcase
    end
  // Digit-entry register; clear overrides a simultaneous accept
  always_ff @(posedge CLK)
    if (RST || clr) begin
      dataout_q <= '0;
      cnt_q     <= '0;
    end else if (accept_d) begin
      dataout_q <= {dataout_q[27:0], cand};
      cnt_q     <= cnt_q == 4'd8 ? cnt_q : cnt_q + 4'd1;
    end
endmodule

// File: tb/tb_keypad_scan_zyq.sv
// tb_keypad_scan_zyq: randomized and directed frame-level check of keypad_scan_zyq against a press-history model
module tb_keypad_scan_zyq;
  localparam int SD = 4;
  localparam int DEB = 2;
  localparam int FRAME = 4 * SD;
  logic        CLK = 1'b0, RST = 1'b1, clr = 1'b0;
  logic [3:0]  row_n, col_n, key_code, digit_cnt;
  logic        key_valid;
  logic [31:0] dataout;
  logic [15:0] pressed = '0;
  int checks = 0, errors = 0, pulses = 0, m_total = 0;
  bit m_armed = 1'b1;
  int m_run = 0, m_none = 0, m_key = 0;
  logic [3:0] m_code = '0;
  int q[$];
  keypad_scan_zyq #(.SCAN_DIV(SD), .DEBOUNCE(DEB)) dut (
    .CLK(CLK), .RST(RST), .clr(clr), .row_n(row_n), .col_n(col_n),
    .key_valid(key_valid), .key_code(key_code), .dataout(dataout), .digit_cnt(digit_cnt)
  );
  always #5 CLK = ~CLK;
  assign row_n = ~{|(pressed[15:12] & ~col_n), |(pressed[11:8] & ~col_n),
                   |(pressed[7:4] & ~col_n), |(pressed[3:0] & ~col_n)};
  always @(negedge CLK) if (key_valid === 1'b1) pulses++;
  function automatic logic [31:0] exp_data();
    logic [31:0] d = '0;
    foreach (q[i]) d = {d[27:0], 4'(q[i])};
    return d;
  endfunction
  task automatic model_reset();
    m_armed = 1'b1; m_run = 0; m_none = 0; m_key = 0; m_code = '0; q.delete();
  endtask
  task automatic model_frame(input logic [15:0] keys, input bit do_clr, output bit acc);
    int n = $countones(keys);
    int c = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) c = i;
    acc = 1'b0;
    if (n == 1) begin
      m_run = (m_run > 0 && c == m_key) ? m_run + 1 : 1;
      m_key = c;
      m_none = 0;
    end else if (n == 0) begin
      m_none++;
      m_run = 0;
    end else begin
      m_run = 0;
      m_none = 0;
    end
    if (m_armed && n == 1 && m_run == DEB) begin
      acc = 1'b1;
      m_armed = 1'b0;
      m_code = 4'(m_key);
      q.push_back(m_key);
      if (q.size() > 8) void'(q.pop_front());
    end else if (!m_armed && m_none >= DEB) m_armed = 1'b1;
    if (do_clr) q.delete();
  endtask
  task automatic frame(input logic [15:0] keys, input bit do_clr);
    bit acc;
    pressed = keys;
    for (int k = 0; k < FRAME; k++) begin
      checks++;
      if (col_n !== ~(4'b0001 << (k / SD))) begin
        errors++;
        $display("FAIL col_n cycle %0d got %b exp %b", k, col_n, ~(4'b0001 << (k / SD)));
      end
      if (k == FRAME - 1) clr = do_clr;
      @(posedge CLK); #1;
      clr = 1'b0;
    end
    model_frame(keys, do_clr, acc);
    checks += 5;
    if (key_valid !== acc) begin errors++; $display("FAIL key_valid got %b exp %b", key_valid, acc); end
    if (key_code !== m_code) begin errors++; $display("FAIL key_code got %h exp %h", key_code, m_code); end
    if (dataout !== exp_data()) begin errors++; $display("FAIL dataout got %h exp %h", dataout, exp_data()); end
    if (digit_cnt !== 4'(q.size())) begin errors++; $display("FAIL digit_cnt got %0d exp %0d", digit_cnt, q.size()); end
    if (pulses != m_total) begin errors++; $display("FAIL pulse_count got %0d exp %0d", pulses, m_total); end
    m_total += int'(acc);
  endtask
  task automatic check_reset_outputs(input string tag);
    checks += 5;
    if (col_n !== 4'b1110) begin errors++; $display("FAIL %s col_n got %b exp 1110", tag, col_n); end
    if (key_valid !== 1'b0) begin errors++; $display("FAIL %s key_valid got %b exp 0", tag, key_valid); end
    if (key_code !== 4'h0) begin errors++; $display("FAIL %s key_code got %h exp 0", tag, key_code); end
    if (dataout !== 32'h0) begin errors++; $display("FAIL %s dataout got %h exp 0", tag, dataout); end
    if (digit_cnt !== 4'h0) begin errors++; $display("FAIL %s digit_cnt got %0d exp 0", tag, digit_cnt); end
  endtask
  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST = 1'b0;
    model_reset();
  endtask
  task automatic test_single_key();
    repeat (2) frame(16'h0040, 1'b0);
    checks += 3;
    if (key_code !== 4'h6) begin errors++; $display("FAIL single_code got %h exp 6", key_code); end
    if (dataout !== 32'h6) begin errors++; $display("FAIL single_data got %h exp 00000006", dataout); end
    if (digit_cnt !== 4'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", digit_cnt); end
    repeat (3) frame(16'h0040, 1'b0);
    repeat (2) frame(16'h0000, 1'b0);
  endtask
  task automatic test_sequence();
    int p0 = m_total;
    for (int d = 1; d <= 10; d++) begin
      repeat (2) frame(16'(1 << d), 1'b0);
      repeat (2) frame(16'h0000, 1'b0);
    end
    checks += 3;
    if (dataout !== 32'h3456789A) begin errors++; $display("FAIL seq_data got %h exp 3456789a", dataout); end
    if (digit_cnt !== 4'd8) begin errors++; $display("FAIL seq_cnt got %0d exp 8", digit_cnt); end
    if (pulses - p0 != 10) begin errors++; $display("FAIL seq_pulses got %0d exp 10", pulses - p0); end
  endtask
  task automatic test_bounce();
    int p0 = pulses;
    for (int i = 0; i < 3; i++) begin
      frame(16'h0020, 1'b0);
      frame(16'h0000, 1'b0);
    end
    checks++;
    if (pulses != p0) begin errors++; $display("FAIL bounce_pulses got %0d exp %0d", pulses, p0); end
    repeat (2) frame(16'h0020, 1'b0);
    checks += 2;
    if (key_valid !== 1'b1) begin errors++; $display("FAIL bounce_valid got %b exp 1", key_valid); end
    if (key_code !== 4'h5) begin errors++; $display("FAIL bounce_code got %h exp 5", key_code); end
    repeat (2) frame(16'h0000, 1'b0);
  endtask
  task automatic test_two_keys();
    repeat (2) frame(16'h0009, 1'b0);
    repeat (2) frame(16'h0001, 1'b0);
    checks += 2;
    if (key_valid !== 1'b1) begin errors++; $display("FAIL two_valid got %b exp 1", key_valid); end
    if (key_code !== 4'h0) begin errors++; $display("FAIL two_code got %h exp 0", key_code); end
    repeat (2) frame(16'h0000, 1'b0);
  endtask
  task automatic test_clr_accept();
    frame(16'h0000, 1'b1);
    repeat (2) frame(16'h0002, 1'b0);
    repeat (2) frame(16'h0000, 1'b0);
    repeat (2) frame(16'h0004, 1'b0);
    repeat (2) frame(16'h0000, 1'b0);
    checks++;
    if (dataout !== 32'h12) begin errors++; $display("FAIL clr_pre_data got %h exp 00000012", dataout); end
    frame(16'h0800, 1'b0);
    frame(16'h0800, 1'b1);
    checks += 4;
    if (key_valid !== 1'b1) begin errors++; $display("FAIL clr_valid got %b exp 1", key_valid); end
    if (key_code !== 4'hB) begin errors++; $display("FAIL clr_code got %h exp b", key_code); end
    if (dataout !== 32'h0) begin errors++; $display("FAIL clr_data got %h exp 0", dataout); end
    if (digit_cnt !== 4'd0) begin errors++; $display("FAIL clr_cnt got %0d exp 0", digit_cnt); end
    repeat (2) frame(16'h0000, 1'b0);
  endtask
  task automatic test_reset_mid();
    frame(16'h0200, 1'b0);
    frame(16'h0200, 1'b0);
    repeat (2) frame(16'h0000, 1'b0);
    frame(16'h0200, 1'b0);
    repeat (5) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    check_reset_outputs("mid_reset");
    RST = 1'b0;
    model_reset();
    frame(16'h0200, 1'b0);
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_early got %b exp 0", key_valid); end
    frame(16'h0200, 1'b0);
    checks += 2;
    if (key_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got %b exp 1", key_valid); end
    if (key_code !== 4'h9) begin errors++; $display("FAIL mid_code got %h exp 9", key_code); end
    repeat (2) frame(16'h0000, 1'b0);
  endtask
  task automatic test_random();
    for (int f = 0; f < 90; f++) begin
      int r = int'($urandom_range(0, 9));
      int a = int'($urandom_range(0, 15));
      int b = (a + int'($urandom_range(1, 15))) % 16;
      logic [15:0] keys;
      keys = r < 4 ? 16'h0 : r < 8 ? 16'(1 << (int'($urandom_range(0, 3)) * 5)) :
             r == 8 ? 16'((1 << a) | (1 << b)) : 16'(1 << a);
      frame(keys, $urandom_range(0, 15) == 0);
    end
    repeat (2) frame(16'h0000, 1'b0);
  endtask
  initial begin
    test_reset();
    test_single_key();
    test_sequence();
    test_bounce();
    test_two_keys();
    test_clr_accept();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
